// File: rtl/arith_result_unit.sv
// arith_result_unit: single-cycle add/subtract/clear and a bit-serial
// shift-add multiply (one multiplier bit per cycle, LSB first).
// Results are registered and held until the next accepted operation.
module arith_result_unit #(
   parameter int NUM_WIDTH = 8,
   parameter int ANS_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic [NUM_WIDTH-1:0] left_in,
   input  logic [NUM_WIDTH-1:0] right_in,
   output logic [ANS_WIDTH-1:0] answer_out,
   output logic                 pos_neg,
   output logic                 overflow,
   output logic                 busy,
   output logic                 done
);

   localparam int ACC_W = 2 * NUM_WIDTH;
   // Wide enough to hold both the full product and a full answer word, so
   // overflow detection is a single "anything above ANS_WIDTH" test.
   localparam int RES_W = (ACC_W > ANS_WIDTH) ? ACC_W : ANS_WIDTH;
   localparam int CNT_W = $clog2(NUM_WIDTH + 1);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MUL    = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [1:0]           op_q;
   logic [ACC_W-1:0]     acc;
   logic [ACC_W-1:0]     mcand;
   logic [NUM_WIDTH-1:0] mplier;
   logic [CNT_W-1:0]     bit_cnt;

   logic [RES_W-1:0]     quick_val;
   logic                 quick_neg;
   logic [RES_W-1:0]     left_ext;
   logic [RES_W-1:0]     right_ext;
   logic [ACC_W-1:0]     acc_step;

   // Split a wide result into {overflow, low ANS_WIDTH bits}.
   function automatic logic [ANS_WIDTH:0] fit_ans(input logic [RES_W-1:0] v);
      return {|(v >> ANS_WIDTH), v[ANS_WIDTH-1:0]};
   endfunction

   assign left_ext  = RES_W'(left_in);
   assign right_ext = RES_W'(right_in);

   // One shift-add step: add the shifted multiplicand when the current
   // multiplier LSB is set.
   assign acc_step = mplier[0] ? (acc + mcand) : acc;

   assign busy = (state == MUL);

   // Single-cycle result for add / subtract / clear, magnitude plus sign.
   always_comb begin
      quick_val = '0;
      quick_neg = 1'b0;
      case (op)
         OP_ADD: quick_val = left_ext + right_ext;
         OP_SUB: begin
            if (right_in > left_in) begin
               quick_val = right_ext - left_ext;
               quick_neg = 1'b1;
            end else begin
               quick_val = left_ext - right_ext;
            end
         end
         default: quick_val = '0;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: only a multiply leaves IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start && (op == OP_MUL)) begin
               state_nxt = MUL;
            end
         end
         MUL: begin
            if (bit_cnt == CNT_W'(NUM_WIDTH - 1)) begin
               state_nxt = FINISH;
            end
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand latch, multiply iteration and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q       <= '0;
         acc        <= '0;
         mcand      <= '0;
         mplier     <= '0;
         bit_cnt    <= '0;
         answer_out <= '0;
         pos_neg    <= 1'b0;
         overflow   <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_q    <= op;
                  mcand   <= ACC_W'(left_in);
                  mplier  <= right_in;
                  acc     <= '0;
                  bit_cnt <= '0;
                  if (op != OP_MUL) begin
                     {overflow, answer_out} <= fit_ans(quick_val);
                     pos_neg                <= quick_neg;
                     done                   <= 1'b1;
                  end
               end
            end
            MUL: begin
               acc     <= acc_step;
               mcand   <= mcand << 1;
               mplier  <= mplier >> 1;
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
            FINISH: begin
               if (op_q == OP_MUL) begin
                  {overflow, answer_out} <= fit_ans(RES_W'(acc));
                  pos_neg                <= 1'b0;
                  done                   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_arith_result_unit.sv
// Bench for arith_result_unit: a default build and an ANS_WIDTH=12 build
// share one stimulus stream; expected results are queued at issue time
// and popped when each instance pulses done.
module tb_arith_result_unit;

   localparam int NW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    op = 2'b00;
   logic [NW-1:0] left_in = '0;
   logic [NW-1:0] right_in = '0;

   logic [15:0]   ans_a;
   logic          neg_a, ovf_a, busy_a, done_a;
   logic [11:0]   ans_b;
   logic          neg_b, ovf_b, busy_b, done_b;

   typedef struct {
      int ans;
      bit neg;
      bit ovf;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   int n_total = 0;
   int n_bad = 0;

   arith_result_unit #(.NUM_WIDTH(NW), .ANS_WIDTH(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .left_in(left_in), .right_in(right_in),
      .answer_out(ans_a), .pos_neg(neg_a), .overflow(ovf_a),
      .busy(busy_a), .done(done_a)
   );

   arith_result_unit #(.NUM_WIDTH(NW), .ANS_WIDTH(12)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .left_in(left_in), .right_in(right_in),
      .answer_out(ans_b), .pos_neg(neg_b), .overflow(ovf_b),
      .busy(busy_b), .done(done_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Arithmetic reference on plain integers.
   function automatic exp_t model(input logic [1:0] o, input int a, input int b, input int aw);
      exp_t   e;
      longint v;
      longint lim;
      e.neg = 1'b0;
      case (o)
         2'd0: v = longint'(a) + longint'(b);
         2'd1: begin
            if (b > a) begin
               v = longint'(b) - longint'(a);
               e.neg = 1'b1;
            end else begin
               v = longint'(a) - longint'(b);
            end
         end
         2'd2: v = longint'(a) * longint'(b);
         default: v = 0;
      endcase
      lim   = longint'(1) << aw;
      e.ans = int'(v % lim);
      e.ovf = (v >= lim);
      return e;
   endfunction

   // Scoreboard for the 16-bit build.
   always @(negedge clk) begin
      exp_t e;
      if (done_a) begin
         if (q_a.size() == 0) begin
            chk("spurious_done_a", 32'(done_a), 32'd0);
         end else begin
            e = q_a.pop_front();
            chk("ans_a", 32'(ans_a), 32'(e.ans));
            chk("neg_a", 32'(neg_a), 32'(e.neg));
            chk("ovf_a", 32'(ovf_a), 32'(e.ovf));
         end
      end
   end

   // Scoreboard for the 12-bit build.
   always @(negedge clk) begin
      exp_t e;
      if (done_b) begin
         if (q_b.size() == 0) begin
            chk("spurious_done_b", 32'(done_b), 32'd0);
         end else begin
            e = q_b.pop_front();
            chk("ans_b", 32'(ans_b), 32'(e.ans));
            chk("neg_b", 32'(neg_b), 32'(e.neg));
            chk("ovf_b", 32'(ovf_b), 32'(e.ovf));
         end
      end
   end

   // Issue one operation, scramble inputs while it runs, and check latency,
   // busy length and a single-cycle done. Optionally fires a stray start
   // while the multiply is busy.
   task automatic run_op(input logic [1:0] o, input int a, input int b, input bit inject);
      int lat;
      int bsy;
      int exp_lat;
      int exp_bsy;
      bit got;
      op       = o;
      left_in  = a[NW-1:0];
      right_in = b[NW-1:0];
      start    = 1'b1;
      q_a.push_back(model(o, a, b, 16));
      q_b.push_back(model(o, a, b, 12));
      exp_lat = (o == 2'd2) ? NW + 2 : 1;
      exp_bsy = (o == 2'd2) ? NW : 0;
      lat = 0;
      bsy = 0;
      got = 1'b0;
      while (!got && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         start = 1'b0;
         if (inject && lat == 3) begin
            start    = 1'b1;
            op       = 2'd0;
            left_in  = 8'($urandom);
            right_in = 8'($urandom);
         end else begin
            op       = 2'($urandom);
            left_in  = 8'($urandom);
            right_in = 8'($urandom);
         end
         if (busy_a) bsy++;
         if (done_a) got = 1'b1;
      end
      start = 1'b0;
      chk("done_seen", 32'(got), 32'd1);
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("busy_cycles", 32'(bsy), 32'(exp_bsy));
      chk("done_b_aligned", 32'(done_b), 32'd1);
      @(posedge clk);
      #1;
      chk("done_width", 32'(done_a), 32'd0);
   endtask

   initial begin
      // Reset values while rst_n is held low.
      #2;
      chk("rst_ans", 32'(ans_a), 32'd0);
      chk("rst_neg", 32'(neg_a), 32'd0);
      chk("rst_ovf", 32'(ovf_a), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op(2'd0, 200, 100, 1'b0);
      run_op(2'd1, 5, 9, 1'b0);
      run_op(2'd1, 7, 7, 1'b0);
      run_op(2'd1, 9, 5, 1'b0);
      run_op(2'd0, 255, 255, 1'b0);
      run_op(2'd2, 255, 255, 1'b0);
      run_op(2'd2, 0, 200, 1'b0);
      run_op(2'd2, 13, 11, 1'b1);
      run_op(2'd2, 255, 255, 1'b0);

      // Clear after an overflowing result, then outputs must stay put.
      run_op(2'd3, 17, 3, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk("clr_hold_ans", 32'(ans_a), 32'd0);
         chk("clr_hold_ovf_b", 32'(ovf_b), 32'd0);
         chk("clr_hold_done", 32'(done_a), 32'd0);
      end

      for (int i = 0; i < 8; i++) begin
         run_op(2'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), 1'b0);
      end

      // Abort a multiply with reset partway through.
      run_op(2'd2, 200, 100, 1'b0);
      op       = 2'd2;
      left_in  = 8'd13;
      right_in = 8'd11;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("abort_busy_before", 32'(busy_a), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_ans_a", 32'(ans_a), 32'd0);
      chk("abort_ans_b", 32'(ans_b), 32'd0);
      chk("abort_neg", 32'(neg_a), 32'd0);
      chk("abort_ovf_b", 32'(ovf_b), 32'd0);
      chk("abort_busy", 32'(busy_a), 32'd0);
      chk("abort_done", 32'(done_a), 32'd0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      run_op(2'd0, 1, 1, 1'b0);

      // Result holds with no further start.
      repeat (3) @(posedge clk);
      #1;
      chk("hold_ans", 32'(ans_a), 32'd2);
      chk("hold_done", 32'(done_a), 32'd0);

      chk("queue_a_empty", 32'(q_a.size()), 32'd0);
      chk("queue_b_empty", 32'(q_b.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
